// File: rtl/uart_tx_fifo.sv
// Transmit holding FIFO between the UART register block and the transmitter.
// First-word-fall-through, with fill level, sticky overflow and a low-watermark interrupt.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LOG_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [LOG_DEPTH:0]    elements_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i,
    input  logic [LOG_DEPTH:0]    thr_i,
    output logic                  thr_irq_o,
    input  logic                  en_i
);

    localparam int unsigned DEPTH = 2 ** LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] DEPTH_CNT = (LOG_DEPTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [LOG_DEPTH-1:0]  r_wr_ptr;
    logic [LOG_DEPTH-1:0]  r_rd_ptr;
    logic [LOG_DEPTH:0]    r_count;
    logic                  r_ovf;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    always_comb begin
        w_full  = (r_count == DEPTH_CNT);
        w_empty = (r_count == '0);
        // ready_o depends only on the count, so a pop never frees space in the same cycle
        w_push  = valid_i & ~w_full;
        w_pop   = ~w_empty & ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // Clear wins over a same-cycle overflow
            if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end else if (valid_i && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !clr_i && w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_comb begin
        ready_o    = ~w_full;
        valid_o    = ~w_empty;
        data_o     = r_mem[r_rd_ptr];
        elements_o = r_count;
        full_o     = w_full;
        empty_o    = w_empty;
        ovf_o      = r_ovf;
        thr_irq_o  = en_i & (r_count <= thr_i);
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a queue scoreboard tracks accepted bytes and
// a small reference model tracks count, overflow and interrupt level.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst, clr, valid, ready, ovf_clr, en;
    logic [7:0] data;
    logic [4:0] thr;
    logic       ready_o, valid_o, full_o, empty_o, ovf_o, thr_irq_o;
    logic [7:0] data_o;
    logic [4:0] elements_o;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] sb_q[$];
    int         m_cnt = 0;
    logic       m_ovf = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_WIDTH(8), .LOG_DEPTH(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (clr),
        .data_i    (data),
        .valid_i   (valid),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready),
        .elements_o(elements_o),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .ovf_o     (ovf_o),
        .ovf_clr_i (ovf_clr),
        .thr_i     (thr),
        .thr_irq_o (thr_irq_o),
        .en_i      (en)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Update the model from the current inputs, advance one edge, compare outputs.
    task automatic step();
        logic push_ok, pop_ok;
        if (rst || clr) begin
            sb_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            push_ok = valid && (m_cnt < 16);
            pop_ok  = ready && (m_cnt > 0);
            if (pop_ok) begin
                check("pop_data", {24'h0, data_o}, {24'h0, sb_q[0]});
                void'(sb_q.pop_front());
            end
            if (push_ok) sb_q.push_back(data);
            if (ovf_clr) m_ovf = 1'b0;
            else if (valid && m_cnt == 16) m_ovf = 1'b1;
            m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
        end
        @(posedge clk);
        #1;
        check("elements", {27'h0, elements_o}, m_cnt);
        check("valid_o", {31'h0, valid_o}, {31'h0, m_cnt != 0});
        check("ready_o", {31'h0, ready_o}, {31'h0, m_cnt != 16});
        check("full_o", {31'h0, full_o}, {31'h0, m_cnt == 16});
        check("empty_o", {31'h0, empty_o}, {31'h0, m_cnt == 0});
        check("ovf_o", {31'h0, ovf_o}, {31'h0, m_ovf});
        check("thr_irq", {31'h0, thr_irq_o}, {31'h0, en && (m_cnt <= int'(thr))});
        if (m_cnt != 0) check("head", {24'h0, data_o}, {24'h0, sb_q[0]});
    endtask

    task automatic push(input logic [7:0] d);
        valid = 1'b1;
        data  = d;
        step();
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; valid = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
        en = 1'b1; thr = 5'd0; data = 8'h00;
        #1;
        step();
        check("reset_irq_eq_en", {31'h0, thr_irq_o}, 32'h1);
        rst = 1'b0;
        en  = 1'b0;

        // Basic push then drain
        push(8'h41); push(8'h42); push(8'h43);
        check("t1_elements", {27'h0, elements_o}, 32'd3);
        check("t1_head", {24'h0, data_o}, 32'h41);
        ready = 1'b1;
        repeat (3) step();
        ready = 1'b0;
        check("t1_empty", {31'h0, empty_o}, 32'h1);

        // Fill, overflow, drain, sticky flag
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'hAA);
        check("t2_full", {31'h0, full_o}, 32'h1);
        check("t2_ovf", {31'h0, ovf_o}, 32'h1);
        check("t2_elements", {27'h0, elements_o}, 32'd16);
        // Pop while full with a push attempt: push must be refused
        ready = 1'b1; valid = 1'b1; data = 8'hBB;
        step();
        valid = 1'b0;
        repeat (15) step();
        ready = 1'b0;
        check("t2_ovf_sticky", {31'h0, ovf_o}, 32'h1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("t2_ovf_cleared", {31'h0, ovf_o}, 32'h0);

        // Steady-state push+pop across pointer wrap
        for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
        valid = 1'b1; ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data = 8'(8'h10 + i);
            step();
        end
        check("t3_elements", {27'h0, elements_o}, 32'd8);
        valid = 1'b0;
        repeat (8) step();

        // Push-to-valid latency, no bypass
        push(8'h55);
        check("t4_valid", {31'h0, valid_o}, 32'h1);
        step();
        check("t4_empty", {31'h0, empty_o}, 32'h1);
        ready = 1'b0;

        // Low-watermark interrupt
        en = 1'b1; thr = 5'd2;
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        check("t5_irq_at5", {31'h0, thr_irq_o}, 32'h0);
        ready = 1'b1;
        repeat (2) step();
        check("t5_irq_at3", {31'h0, thr_irq_o}, 32'h0);
        step();
        check("t5_irq_at2", {31'h0, thr_irq_o}, 32'h1);
        ready = 1'b0;
        thr = 5'd20; step();
        check("t5_irq_thr_big", {31'h0, thr_irq_o}, 32'h1);
        en = 1'b0; step();
        check("t5_irq_dis", {31'h0, thr_irq_o}, 32'h0);
        thr = 5'd2;

        // Flush and reset with pending push/pop, plus set/clear overflow race
        for (int r = 0; r < 2; r++) begin
            while (m_cnt < 16) push(8'(8'hC0 + m_cnt));
            valid = 1'b1; ovf_clr = 1'b1; data = 8'hEE;
            step();
            check("ovf_clr_wins", {31'h0, ovf_o}, 32'h0);
            ovf_clr = 1'b0;
            step();
            valid = 1'b0; ready = 1'b1;
            repeat (6) step();
            check("pre_flush_cnt", {27'h0, elements_o}, 32'd10);
            valid = 1'b1; data = 8'h77;
            if (r == 0) clr = 1'b1; else rst = 1'b1;
            step();
            clr = 1'b0; rst = 1'b0; valid = 1'b0; ready = 1'b0;
            check("flush_elements", {27'h0, elements_o}, 32'd0);
            check("flush_ovf", {31'h0, ovf_o}, 32'h0);
            check("flush_empty", {31'h0, empty_o}, 32'h1);
        end

        // Reuse after flush
        push(8'h99);
        check("post_flush_head", {24'h0, data_o}, 32'h99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit holding FIFO for the APB UART. Sits directly upstream of the UART transmitter.
- Accepts bytes from the register interface's TX-holding write port.
- Presents them to the transmitter via valid/ready: data_o/valid_o drive tx_data_i/tx_valid_i; ready_i comes from tx_ready_o.
- Also provides the fill level, a sticky overflow flag, and a low-watermark interrupt for the register block.

Parameters:
- DATA_WIDTH, 8, width of each entry.
- LOG_DEPTH, 4, log2 of entry count; DEPTH = 2**LOG_DEPTH = 16. Must be >= 1.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- clr_i  input  1  synchronous flush (register-block FIFO-reset bit).
- data_i  input  DATA_WIDTH  push data.
- valid_i  input  1  push request.
- ready_o  output  1  FIFO can accept a push.
- data_o  output  DATA_WIDTH  head entry, first-word-fall-through.
- valid_o  output  1  head entry valid.
- ready_i  input  1  consumer accepts head.
- elements_o  output  LOG_DEPTH+1  current fill count, 0..DEPTH.
- full_o  output  1  elements_o == DEPTH.
- empty_o  output  1  elements_o == 0.
- ovf_o  output  1  sticky overflow flag.
- ovf_clr_i  input  1  clears ovf_o.
- thr_i  input  LOG_DEPTH+1  low-watermark level.
- thr_irq_o  output  1  high when elements_o <= thr_i and FIFO enabled.
- en_i  input  1  interrupt enable.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array.
  - wr_ptr, rd_ptr are LOG_DEPTH bits and wrap modulo DEPTH with no explicit compare.
  - count register is LOG_DEPTH+1 bits.
- Reset (rst_i=1 at clock edge): wr_ptr=0, rd_ptr=0, count=0, ovf_o=0. Array contents are not reset.
  - Resulting outputs: valid_o=0, ready_o=1, empty_o=1, full_o=0, elements_o=0.
  - thr_irq_o = en_i & (0 <= thr_i), i.e. equals en_i.
  - rst_i mid-stream discards all entries.
- Push: accepted when valid_i & ready_o. ready_o = ~full_o, purely from count; there is no combinational path from ready_i.
  - On acceptance: mem[wr_ptr] <= data_i, wr_ptr increments.
- Pop: accepted when valid_o & ready_i. valid_o = ~empty_o and data_o = mem[rd_ptr], both combinational from registers.
  - On acceptance: rd_ptr increments.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, both pointers advance.
  - Legal when 0 < count < DEPTH.
- Full: push is refused (ready_o=0). A simultaneous pop still completes. Freed space is visible the next cycle; full-state pushes are never accepted in the same cycle as the pop.
- Empty: no bypass. A byte pushed at edge N gives valid_o=1 after edge N; earliest pop is at edge N+1.
  - Push-to-valid latency is 1 cycle.
  - valid_o stays low while empty regardless of ready_i.
- Overflow: valid_i=1 while full_o=1 at a clock edge sets ovf_o=1. The byte is dropped and pointers are unchanged.
  - ovf_o holds until ovf_clr_i=1 or clr_i=1 or rst_i=1.
  - If set and clear occur in the same cycle, clear wins.
- Flush: clr_i=1 at an edge sets pointers=0, count=0, ovf_o=0.
  - Any push or pop in the same cycle is ignored.
  - Priority: rst_i > clr_i > push/pop.
- Threshold interrupt: thr_irq_o = en_i & (elements_o <= thr_i). It is combinational from registered count.
  - thr_i >= DEPTH forces the condition true.
  - The interrupt is level, not sticky; the register block handles pending/clear.
- data_o while empty is don't-care (stale contents). Verification must not check it.

Test Plan:
- Reset then push 0x41,0x42,0x43 on 3 consecutive cycles, ready_i=0 -> elements_o=3, valid_o=1, data_o=0x41; then ready_i=1 for 3 cycles -> data_o sequence 0x41,0x42,0x43, then empty_o=1, valid_o=0.
- Push 16 bytes 0x00..0x0F, then push 0xAA -> full_o=1, ready_o=0, ovf_o=1, elements_o=16; drain shows 0x00..0x0F with 0xAA absent; ovf_o stays 1 until ovf_clr_i pulse.
- Fill to 8, then push+pop every cycle for 40 cycles with incrementing data -> elements_o constant at 8, output order matches input order across pointer wrap.
- Push 0x55 at edge N into empty FIFO with ready_i held 1 -> valid_o rises after edge N, pop at edge N+1, empty_o=1 after edge N+1.
- en_i=1, thr_i=2: counts 5->3 keep thr_irq_o=0; count 2 -> thr_irq_o=1; en_i=0 -> thr_irq_o=0.
- At count 10 with ovf_o=1, assert clr_i together with valid_i and ready_i -> next cycle elements_o=0, ovf_o=0, empty_o=1; repeat with rst_i -> same result.
